// File: rtl/miv_ram_ecc_scrub.sv
// 1W/1R RAM with optional Hamming SECDED around an inferred array, plus a background scrubber,
// saturating error counters, first-error address capture and a write-side fault-injection hook.
module miv_ram_ecc_scrub #(
  parameter int WIDTH          = 20,
  parameter int DEPTH          = 128,
  parameter int ECC_EN         = 1,
  parameter int CNT_W          = 8,
  parameter int SCRUB_INTERVAL = 256,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    WADDR,
  input  logic             WEN,
  input  logic [1:0]       ERR_INJ,
  input  logic [AW-1:0]    RADDR,
  input  logic             REN,
  output logic [WIDTH-1:0] RD,
  output logic             SB_CORRECT,
  output logic             DB_DETECT,
  input  logic             SCRUB_EN,
  output logic             SCRUB_BUSY,
  output logic [CNT_W-1:0] SB_COUNT,
  output logic [CNT_W-1:0] DB_COUNT,
  output logic [AW-1:0]    ERR_ADDR,
  output logic             ERR_VALID,
  input  logic             ERR_CLR
);

  function automatic int calc_p(input int w);
    int p;
    p = 1;
    while ((1 << p) < (w + p + 1)) p++;
    return p;
  endfunction

  localparam int P   = calc_p(WIDTH);
  localparam int N   = WIDTH + P;
  localparam int CW  = (ECC_EN != 0) ? N + 1 : WIDTH;
  localparam int WCW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  // Stored layout is {overall parity, Hamming checks, data}; data bits occupy the
  // non-power-of-two Hamming positions in ascending order.
  function automatic logic [P-1:0] hcheck(input logic [WIDTH-1:0] d);
    logic [P-1:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) c = c ^ P'(pos);
        di++;
      end
    end
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] fix(input logic [WIDTH-1:0] d, input logic [P-1:0] s);
    logic [WIDTH-1:0] r;
    int di;
    r  = d;
    di = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (pos == int'(s)) r[di] = ~d[di];
        di++;
      end
    end
    return r;
  endfunction

  function automatic logic [N:0] encode(input logic [WIDTH-1:0] d);
    logic [P-1:0] c;
    c = hcheck(d);
    return {^{c, d}, c, d};
  endfunction

  typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WRBK} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WCW-1:0]   wait_cnt;
  logic             hazard;
  logic [CW-1:0]    mem [DEPTH];
  logic [CW-1:0]    rd_cw, wr_cw, fix_cw, wb_cw;
  logic [AW-1:0]    rd_addr, rd_sel, wr_sel;
  logic             user_rd;
  logic [WIDTH-1:0] rd_hold, dec_data;
  logic             dec_sb, dec_db;
  logic             scrub_rd, scrub_wr, ptr_hit, ev_chk, sb_ev, db_ev;

  generate
    if (ECC_EN != 0) begin : g_ecc
      logic [P-1:0] syn;
      logic         par_bad, syn_in_range;
      assign syn          = hcheck(rd_cw[WIDTH-1:0]) ^ rd_cw[N-1:WIDTH];
      assign par_bad      = ^rd_cw;
      assign syn_in_range = int'(syn) <= N;
      assign dec_sb       = par_bad && syn_in_range;
      // A syndrome pointing past the codeword cannot come from one flip.
      assign dec_db       = (syn != '0) && (!par_bad || !syn_in_range);
      assign dec_data     = dec_sb ? fix(rd_cw[WIDTH-1:0], syn) : rd_cw[WIDTH-1:0];
      assign wr_cw        = encode(WD) ^ CW'(ERR_INJ);
      assign fix_cw       = encode(dec_data);
    end else begin : g_raw
      assign dec_sb   = 1'b0;
      assign dec_db   = 1'b0;
      assign dec_data = rd_cw;
      assign wr_cw    = WD ^ CW'(ERR_INJ);
      assign fix_cw   = rd_cw;
    end
  endgenerate

  // User traffic owns both ports; the scrubber only uses an idle port.
  assign scrub_rd = (state == READ) && SCRUB_EN && !REN;
  assign scrub_wr = (state == WRBK) && !WEN;
  assign ptr_hit  = WEN && (WADDR == ptr);
  assign rd_sel   = REN ? RADDR : ptr;
  assign wr_sel   = WEN ? WADDR : ptr;

  always_ff @(posedge CLK) begin
    if (WEN || scrub_wr) mem[wr_sel] <= WEN ? wr_cw : wb_cw;
    if (REN || scrub_rd) rd_cw <= mem[rd_sel];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      user_rd <= 1'b0;
      rd_addr <= '0;
      rd_hold <= '0;
    end else begin
      user_rd <= REN;
      if (REN || scrub_rd) rd_addr <= rd_sel;
      if (user_rd) rd_hold <= dec_data;
    end
  end

  assign RD         = user_rd ? dec_data : rd_hold;
  assign SB_CORRECT = user_rd && dec_sb;
  assign DB_DETECT  = user_rd && dec_db;

  assign ev_chk = user_rd || (state == CHECK);
  assign sb_ev  = ev_chk && dec_sb;
  assign db_ev  = ev_chk && dec_db;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SB_COUNT  <= '0;
      DB_COUNT  <= '0;
      ERR_ADDR  <= '0;
      ERR_VALID <= 1'b0;
    end else if (ERR_CLR) begin
      SB_COUNT  <= '0;
      DB_COUNT  <= '0;
      ERR_ADDR  <= '0;
      ERR_VALID <= 1'b0;
    end else begin
      if (sb_ev && (SB_COUNT != '1)) SB_COUNT <= SB_COUNT + 1'b1;
      if (db_ev && (DB_COUNT != '1)) DB_COUNT <= DB_COUNT + 1'b1;
      if ((sb_ev || db_ev) && !ERR_VALID) begin
        ERR_VALID <= 1'b1;
        ERR_ADDR  <= rd_addr;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      ptr        <= '0;
      wait_cnt   <= '0;
      wb_cw      <= '0;
      hazard     <= 1'b0;
      SCRUB_BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: if (SCRUB_EN && (ECC_EN != 0)) begin
          state      <= WAIT;
          wait_cnt   <= '0;
          SCRUB_BUSY <= 1'b1;
        end
        WAIT: if (!SCRUB_EN) begin
          state      <= IDLE;
          SCRUB_BUSY <= 1'b0;
        end else if (wait_cnt == WCW'(SCRUB_INTERVAL - 1)) begin
          state <= READ;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        READ: if (!SCRUB_EN) begin
          state      <= IDLE;
          SCRUB_BUSY <= 1'b0;
        end else if (!REN) begin
          state  <= CHECK;
          // A write landing with our read returned stale data; never write it back.
          hazard <= ptr_hit;
        end
        CHECK: if (dec_sb && !ptr_hit && !hazard) begin
          state <= WRBK;
          wb_cw <= fix_cw;
        end else begin
          ptr        <= ptr + 1'b1;
          wait_cnt   <= '0;
          state      <= SCRUB_EN ? WAIT : IDLE;
          SCRUB_BUSY <= SCRUB_EN;
        end
        WRBK: if (!WEN || ptr_hit) begin
          ptr        <= ptr + 1'b1;
          wait_cnt   <= '0;
          state      <= SCRUB_EN ? WAIT : IDLE;
          SCRUB_BUSY <= SCRUB_EN;
        end
        default: begin
          state      <= IDLE;
          SCRUB_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miv_ram_ecc_scrub.sv
// Directed bench for miv_ram_ecc_scrub: reads, SEC/DED, scrub writeback, hazards, saturation, reset.
module tb_miv_ram_ecc_scrub;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [19:0] WD;
  logic [3:0]  WADDR;
  logic        WEN;
  logic [1:0]  ERR_INJ;
  logic [3:0]  RADDR;
  logic        REN;
  logic [19:0] RD;
  logic        SB_CORRECT, DB_DETECT;
  logic        SCRUB_EN, SCRUB_BUSY;
  logic [1:0]  SB_COUNT, DB_COUNT;
  logic [3:0]  ERR_ADDR;
  logic        ERR_VALID, ERR_CLR;

  int checks = 0;
  int errors = 0;

  miv_ram_ecc_scrub #(
    .WIDTH(20), .DEPTH(16), .ECC_EN(1), .CNT_W(2), .SCRUB_INTERVAL(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .WD(WD), .WADDR(WADDR), .WEN(WEN), .ERR_INJ(ERR_INJ),
    .RADDR(RADDR), .REN(REN), .RD(RD), .SB_CORRECT(SB_CORRECT), .DB_DETECT(DB_DETECT),
    .SCRUB_EN(SCRUB_EN), .SCRUB_BUSY(SCRUB_BUSY), .SB_COUNT(SB_COUNT), .DB_COUNT(DB_COUNT),
    .ERR_ADDR(ERR_ADDR), .ERR_VALID(ERR_VALID), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [19:0] d, input logic [1:0] inj);
    WADDR = a; WD = d; ERR_INJ = inj; WEN = 1'b1;
    tick();
    WEN = 1'b0; ERR_INJ = 2'b00;
  endtask

  task automatic rd(input logic [3:0] a);
    RADDR = a; REN = 1'b1;
    tick();
    REN = 1'b0;
  endtask

  task automatic clr();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (RD !== 20'h0) begin errors++; $display("FAIL reset_rd: got %h expected 00000", RD); end
    checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {SB_CORRECT, DB_DETECT}); end
    checks++; if ({SB_COUNT, DB_COUNT} !== 4'h0) begin errors++; $display("FAIL reset_counts: got %h expected 0", {SB_COUNT, DB_COUNT}); end
    checks++; if ({ERR_VALID, ERR_ADDR} !== 5'h0) begin errors++; $display("FAIL reset_err: got %h expected 00", {ERR_VALID, ERR_ADDR}); end
    checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", SCRUB_BUSY); end
  endtask

  task automatic test_clean_read();
    wr(4'd3, 20'h5A5A5, 2'b00);
    rd(4'd3);
    $display("clean read addr 3 rd=%h sb=%b db=%b", RD, SB_CORRECT, DB_DETECT);
    checks++; if (RD !== 20'h5A5A5) begin errors++; $display("FAIL clean_rd: got %h expected 5a5a5", RD); end
    checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL clean_flags: got %b expected 00", {SB_CORRECT, DB_DETECT}); end
    tick();
    checks++; if (SB_COUNT !== 2'd0) begin errors++; $display("FAIL clean_sbcnt: got %0d expected 0", SB_COUNT); end
  endtask

  task automatic test_same_addr();
    WADDR = 4'd3; WD = 20'h11111; WEN = 1'b1; RADDR = 4'd3; REN = 1'b1;
    tick();
    WEN = 1'b0; REN = 1'b0;
    $display("same-addr rw addr 3 rd=%h", RD);
    checks++; if (RD !== 20'h5A5A5) begin errors++; $display("FAIL rw_old: got %h expected 5a5a5", RD); end
    rd(4'd3);
    checks++; if (RD !== 20'h11111) begin errors++; $display("FAIL rw_new: got %h expected 11111", RD); end
  endtask

  task automatic test_single();
    wr(4'd7, 20'h00001, 2'b01);
    rd(4'd7);
    $display("single-err read addr 7 rd=%h sb=%b db=%b", RD, SB_CORRECT, DB_DETECT);
    checks++; if (RD !== 20'h00001) begin errors++; $display("FAIL sb_rd: got %h expected 00001", RD); end
    checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b10) begin errors++; $display("FAIL sb_flags: got %b expected 10", {SB_CORRECT, DB_DETECT}); end
    tick();
    checks++; if (SB_COUNT !== 2'd1) begin errors++; $display("FAIL sb_count: got %0d expected 1", SB_COUNT); end
    checks++; if ({ERR_VALID, ERR_ADDR} !== 5'h17) begin errors++; $display("FAIL sb_erraddr: got %h expected 17", {ERR_VALID, ERR_ADDR}); end
    checks++; if ({SB_CORRECT, RD} !== {1'b0, 20'h00001}) begin errors++; $display("FAIL sb_hold: got %h expected 000001", {SB_CORRECT, RD}); end
  endtask

  task automatic test_double();
    wr(4'd9, 20'h12345, 2'b11);
    rd(4'd9);
    $display("double-err read addr 9 rd=%h sb=%b db=%b", RD, SB_CORRECT, DB_DETECT);
    checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b01) begin errors++; $display("FAIL db_flags: got %b expected 01", {SB_CORRECT, DB_DETECT}); end
    checks++; if (RD !== 20'h12346) begin errors++; $display("FAIL db_raw: got %h expected 12346", RD); end
    tick();
    checks++; if ({DB_COUNT, SB_COUNT} !== 4'b0101) begin errors++; $display("FAIL db_count: got %b expected 0101", {DB_COUNT, SB_COUNT}); end
    checks++; if (ERR_ADDR !== 4'd7) begin errors++; $display("FAIL db_erraddr: got %0d expected 7", ERR_ADDR); end
    wr(4'd7, 20'h0, 2'b00);
    wr(4'd9, 20'h0, 2'b00);
    clr();
    checks++; if ({SB_COUNT, DB_COUNT, ERR_VALID, ERR_ADDR} !== 9'h0) begin errors++; $display("FAIL clr: got %h expected 000", {SB_COUNT, DB_COUNT, ERR_VALID, ERR_ADDR}); end
  endtask

  task automatic test_scrub_fix();
    int n;
    wr(4'd0, 20'h0F0F0, 2'b01);
    SCRUB_EN = 1'b1;
    tick();
    checks++; if (SCRUB_BUSY !== 1'b1) begin errors++; $display("FAIL scrub_busy: got %b expected 1", SCRUB_BUSY); end
    n = 1;
    while (SB_COUNT !== 2'd1 && n < 12) begin tick(); n++; end
    $display("scrub found error after %0d cycles, sb_count=%0d", n, SB_COUNT);
    checks++; if (SB_COUNT !== 2'd1) begin errors++; $display("FAIL scrub_timeout: got sb_count %0d expected 1 within 12 cycles", SB_COUNT); end
    repeat (2) tick();
    rd(4'd0);
    checks++; if ({SB_CORRECT, RD} !== {1'b0, 20'h0F0F0}) begin errors++; $display("FAIL scrub_fixed: got %h expected 00f0f0", {SB_CORRECT, RD}); end
    tick();
    checks++; if ({SB_COUNT, ERR_VALID, ERR_ADDR} !== 7'b01_1_0000) begin errors++; $display("FAIL scrub_cnt: got %b expected 0110000", {SB_COUNT, ERR_VALID, ERR_ADDR}); end
  endtask

  task automatic test_wrbk_hazard();
    clr();
    WADDR = 4'd5; WD = 20'h33333; ERR_INJ = 2'b01; WEN = 1'b1;
    tick();
    ERR_INJ = 2'b00; WADDR = 4'd15; WD = 20'h0;
    repeat (120) tick();
    $display("scrub stalled in writeback busy=%b sb_count=%0d err_addr=%0d", SCRUB_BUSY, SB_COUNT, ERR_ADDR);
    checks++; if ({SCRUB_BUSY, SB_COUNT, ERR_ADDR} !== 7'b1_01_0101) begin errors++; $display("FAIL hz_stall: got %b expected 1010101", {SCRUB_BUSY, SB_COUNT, ERR_ADDR}); end
    WADDR = 4'd5; WD = 20'hABCDE;
    tick();
    WEN = 1'b0;
    repeat (3) tick();
    rd(4'd5);
    $display("hazard read addr 5 rd=%h sb=%b", RD, SB_CORRECT);
    checks++; if (RD !== 20'hABCDE) begin errors++; $display("FAIL hz_data: got %h expected abcde", RD); end
    checks++; if ({SB_CORRECT, DB_DETECT} !== 2'b00) begin errors++; $display("FAIL hz_flags: got %b expected 00", {SB_CORRECT, DB_DETECT}); end
  endtask

  task automatic test_saturation();
    SCRUB_EN = 1'b0;
    repeat (10) tick();
    checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", SCRUB_BUSY); end
    clr();
    wr(4'd10, 20'h55555, 2'b10);
    for (int i = 0; i < 5; i++) begin
      rd(4'd10);
      $display("sat read %0d rd=%h sb=%b count=%0d", i, RD, SB_CORRECT, SB_COUNT);
      checks++; if ({SB_CORRECT, RD} !== {1'b1, 20'h55555}) begin errors++; $display("FAIL sat_rd%0d: got %h expected 155555", i, {SB_CORRECT, RD}); end
    end
    tick();
    checks++; if ({SB_COUNT, DB_COUNT} !== 4'b1100) begin errors++; $display("FAIL sat_count: got %b expected 1100", {SB_COUNT, DB_COUNT}); end
    rd(4'd10);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    checks++; if ({SB_COUNT, ERR_VALID} !== 3'b000) begin errors++; $display("FAIL clr_prio: got %b expected 000", {SB_COUNT, ERR_VALID}); end
  endtask

  task automatic test_reset_mid_scrub();
    SCRUB_EN = 1'b1;
    repeat (3) tick();
    checks++; if (SCRUB_BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", SCRUB_BUSY); end
    RESET = 1'b1;
    #1;
    $display("reset mid-scrub busy=%b", SCRUB_BUSY);
    checks++; if (SCRUB_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", SCRUB_BUSY); end
    SCRUB_EN = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    checks++; if ({SCRUB_BUSY, RD} !== 21'h0) begin errors++; $display("FAIL rst_after: got %h expected 000000", {SCRUB_BUSY, RD}); end
  endtask

  initial begin
    RESET = 1'b1; WD = '0; WADDR = '0; WEN = 1'b0; ERR_INJ = 2'b00;
    RADDR = '0; REN = 1'b0; SCRUB_EN = 1'b0; ERR_CLR = 1'b0;
    repeat (2) tick();
    test_reset();
    RESET = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) wr(4'(a), 20'h0, 2'b00);
    test_clean_read();
    test_same_addr();
    test_single();
    test_double();
    test_scrub_fix();
    test_wrbk_hazard();
    test_saturation();
    test_reset_mid_scrub();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/miv_ram_ecc_scrub.md
Name: miv_ram_ecc_scrub

Overview:
Parametrised two-port (1W/1R) SECDED-protected RAM, the generic successor to the fixed 128x20 ECC macro wrapper. ECC encode/decode is done in RTL around an inferred array, so any width/depth works. It adds a background scrubber that walks the array and writes back corrected words. It also adds saturating error counters, error-address capture and a fault-injection hook. It sits under the core's cache/tag RAMs wherever the fixed ECC RAM was instantiated.

Parameters:
WIDTH, 20, data word width (1..64)
DEPTH, 128, number of words (power of 2, >=4); AW = clog2(DEPTH) localparam
ECC_EN, 1, 1 = SECDED active; 0 = no check bits, SB_CORRECT/DB_DETECT tied 0, scrubber disabled
CNT_W, 8, width of error counters
SCRUB_INTERVAL, 256, idle cycles between scrub steps (>=1)

Ports:
CLK  in  1  clock, all logic posedge
RESET  in  1  asynchronous active-high reset
WD  in  WIDTH  write data
WADDR  in  AW  write address
WEN  in  1  write enable
ERR_INJ  in  2  on a write, bit i set flips stored codeword bit i (test only)
RADDR  in  AW  read address
REN  in  1  read enable
RD  out  WIDTH  corrected read data
SB_CORRECT  out  1  single-bit error corrected on current RD
DB_DETECT  out  1  uncorrectable error on current RD
SCRUB_EN  in  1  enable background scrubbing
SCRUB_BUSY  out  1  scrubber outside IDLE
SB_COUNT  out  CNT_W  saturating count of single-bit events (user reads + scrub)
DB_COUNT  out  CNT_W  saturating count of double-bit events
ERR_ADDR  out  AW  address of first error since clear
ERR_VALID  out  1  ERR_ADDR holds a captured address
ERR_CLR  in  1  clears counters, ERR_VALID, ERR_ADDR (sync, one cycle)

Behaviour:
- Codeword: P Hamming bits (smallest P with 2^P >= WIDTH+P+1) plus overall parity; WIDTH=20 -> 26-bit word. Encode on write; decode on read output path.
- Reset: RD=0, SB_CORRECT=0, DB_DETECT=0, SCRUB_BUSY=0, counters=0, ERR_ADDR=0, ERR_VALID=0, scrub pointer=0, FSM IDLE. Array contents not reset.
- Write: WEN at cycle N -> array updated at end of N.
- Read: REN at N -> RD/flags valid at N+1 and held until the next user read completes.
- Flags are 0 in any cycle not following a user REN.
- Same-address read/write in one cycle returns old data.
- Syndrome 0 with parity ok: clean. Syndrome !=0 with parity bad: single error; flip data bit; SB_CORRECT=1. Syndrome 0 with parity bad: check bit only; SB_CORRECT=1, data unchanged. Syndrome !=0 with parity ok: DB_DETECT=1; RD = raw data bits.
- Counters increment by 1 per event and saturate at 2^CNT_W-1.
- ERR_ADDR/ERR_VALID capture the first event (SB or DB) while ERR_VALID=0.
- ERR_CLR has priority over a same-cycle increment.
- Scrubber FSM, states IDLE, WAIT, READ, CHECK, WRBK:
  - IDLE->WAIT when SCRUB_EN=1 and ECC_EN=1.
  - WAIT counts SCRUB_INTERVAL cycles, then goes to READ.
  - READ issues a read of the scrub pointer only in a cycle with REN=0; otherwise it stalls in READ.
  - CHECK decodes the word. A single error goes to WRBK. Clean or DB goes to WAIT with pointer+1; a DB word is counted but not rewritten.
  - WRBK writes the corrected re-encoded word only in a cycle with WEN=0; otherwise it stalls in WRBK. It then goes to WAIT with pointer+1.
  - Pointer wraps DEPTH-1 -> 0.
- User traffic always wins the ports. The scrubber never stalls the user.
- Hazard: a user write to the scrub pointer address while in CHECK or WRBK cancels the writeback; the FSM proceeds to WAIT with pointer+1.
- SCRUB_EN deassert: the FSM finishes any pending WRBK, then returns to IDLE; the pointer is retained.
- Scrub events update SB/DB counters and ERR_ADDR but never assert SB_CORRECT/DB_DETECT.
- RESET asserted mid-scrub: immediate return to IDLE; a pending writeback is dropped.

Test Plan:
1. Reset, write 0x5A5A5 to addr 3, read addr 3 -> RD=0x5A5A5 next cycle, SB_CORRECT=0, DB_DETECT=0, SB_COUNT=0.
2. Write 0x00001 to addr 7 with ERR_INJ=01, read -> RD=0x00001, SB_CORRECT=1, SB_COUNT=1, ERR_ADDR=7, ERR_VALID=1.
3. Write 0x12345 to addr 9 with ERR_INJ=11, read -> DB_DETECT=1, SB_CORRECT=0, DB_COUNT=1; ERR_ADDR remains 7.
4. SCRUB_EN=1, SCRUB_INTERVAL=4, ERR_INJ=01 on addr 0 -> scrubber writes back within 8 cycles. Subsequent user read of addr 0 -> SB_CORRECT=0, data intact, SB_COUNT incremented once by scrub.
5. Scrubber in WRBK for addr 5 while user writes addr 5 with 0xABCDE -> writeback cancelled; read returns 0xABCDE clean.
6. With CNT_W=2, inject 5 single errors -> SB_COUNT saturates at 3. ERR_CLR -> counters 0, ERR_VALID=0. RESET mid-scrub -> SCRUB_BUSY=0 next edge.
